// File: rtl/dtof_acq_sequencer.sv
// dtof_acq_sequencer: frame controller for one dTOF pixel's two-pass
// (coarse then fine) histogram pipeline. It clears the histogram RAM, gates
// TDC hits during each acquisition pass, hands off to the peak detector and
// the algebraic window block, and latches the final CH/FH peak bins.
//
// Build option: define DTOF_CONT_MODE_EN for free-running frames (DONE
// restarts the coarse clear directly). Left undefined, DONE returns to IDLE
// and each frame needs its own start pulse.
module dtof_acq_sequencer #(
  parameter int NB       = 9,
  parameter int CH_SHOTS = 16,
  parameter int FH_SHOTS = 16,
  parameter int TIMEOUT  = 1023,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          laser_fire,
  input  logic          tdc_valid,
  input  logic          peak_done,
  input  logic          alg_ready,
  input  logic [NB-1:0] peak_ch,
  input  logic [NB-1:0] peak_fh,
  output logic          his_num,
  output logic          hist_wr_en,
  output logic          clr_en,
  output logic [NB-1:0] clr_addr,
  output logic          acq_count_finish,
  output logic          busy,
  output logic          result_valid,
  output logic [NB-1:0] result_ch,
  output logic [NB-1:0] result_fh,
  output logic          timeout_err
);

  typedef enum logic [3:0] {
    IDLE, CLR_CH, ACQ_CH, PEAK_CH, WIN, CLR_FH, ACQ_FH, PEAK_FH, DONE, ERR
  } state_t;

  localparam logic [NB-1:0] CLR_LAST = '1;
  localparam logic [CW-1:0] CH_LAST  = CW'(CH_SHOTS - 1);
  localparam logic [CW-1:0] FH_LAST  = CW'(FH_SHOTS - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CW_ONE   = CW'(1);
  localparam logic [NB-1:0] NB_ONE   = NB'(1);

  state_t        state, state_nx;
  logic [CW-1:0] shot_cnt;
  logic [CW-1:0] to_cnt;

  logic in_acq, in_clr, in_wait, shot_last, to_expire;

  // Decode of the current state used by counters and outputs.
  always_comb begin
    in_acq    = (state == ACQ_CH) || (state == ACQ_FH);
    in_clr    = (state == CLR_CH) || (state == CLR_FH);
    in_wait   = (state == PEAK_CH) || (state == WIN) || (state == PEAK_FH);
    shot_last = laser_fire && (shot_cnt == ((state == ACQ_FH) ? FH_LAST : CH_LAST));
    to_expire = (to_cnt == TO_LAST);
  end

  // Next-state logic; a handshake on the last timeout cycle beats the timeout.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path covered, so no latch is inferred.
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CLR_CH;
      CLR_CH:  if (clr_addr == CLR_LAST) state_nx = ACQ_CH;
      ACQ_CH:  if (shot_last) state_nx = PEAK_CH;
      PEAK_CH: if (peak_done) state_nx = WIN;
               else if (to_expire) state_nx = ERR;
      WIN:     if (alg_ready) state_nx = CLR_FH;
               else if (to_expire) state_nx = ERR;
      CLR_FH:  if (clr_addr == CLR_LAST) state_nx = ACQ_FH;
      ACQ_FH:  if (shot_last) state_nx = PEAK_FH;
      PEAK_FH: if (peak_done) state_nx = DONE;
               else if (to_expire) state_nx = ERR;
`ifdef DTOF_CONT_MODE_EN
      DONE:    state_nx = CLR_CH;
`else
      DONE:    state_nx = IDLE;
`endif
      ERR:     if (start) state_nx = CLR_CH;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge res) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (res) state <= IDLE;
    else     state <= state_nx;
  end

  // Clear address sweeps the whole RAM and wraps to 0 on the last address.
  always_ff @(posedge clk or posedge res) begin
    if (res)         clr_addr <= '0;
    else if (in_clr) clr_addr <= clr_addr + NB_ONE;
    else             clr_addr <= '0;
  end

  // Shot counter: counts laser_fire inside an acquisition pass.
  always_ff @(posedge clk or posedge res) begin
    if (res)                       shot_cnt <= '0;
    else if (!in_acq || shot_last) shot_cnt <= '0;
    else if (laser_fire)           shot_cnt <= shot_cnt + CW_ONE;
  end

  // Handshake timeout counter, restarted on every state change.
  always_ff @(posedge clk or posedge res) begin
    if (res)                    to_cnt <= '0;
    else if (state_nx != state) to_cnt <= '0;
    else if (in_wait)           to_cnt <= to_cnt + CW_ONE;
  end

  // Peak-bin capture on the peak detector handshake.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      result_ch <= '0;
      result_fh <= '0;
    end else begin
      if (state == PEAK_CH && peak_done) result_ch <= peak_ch;
      if (state == PEAK_FH && peak_done) result_fh <= peak_fh;
    end
  end

  // Sticky timeout flag: set on entry to ERR, cleared by the next start.
  always_ff @(posedge clk or posedge res) begin
    if (res)                                    timeout_err <= 1'b0;
    else if (state_nx == ERR && state != ERR)   timeout_err <= 1'b1;
    else if ((state == IDLE || state == ERR) && start) timeout_err <= 1'b0;
  end

  // Moore outputs decoded from the state register; write gating is zero-latency.
  always_comb begin
    his_num          = (state == WIN) || (state == CLR_FH) || (state == ACQ_FH) ||
                       (state == PEAK_FH) || (state == DONE);
    hist_wr_en       = tdc_valid && in_acq;
    clr_en           = in_clr;
    acq_count_finish = (state == PEAK_CH) || (state == PEAK_FH);
    busy             = (state != IDLE) && (state != ERR);
    result_valid     = (state == DONE);
  end

endmodule

// File: tb/tb_dtof_acq_sequencer.sv
// Testbench for dtof_acq_sequencer: directed frames with a result scoreboard.
// Expected peak pairs are queued when the FH peak handshake is issued; a
// negedge monitor pops and compares whenever result_valid is seen.
module tb_dtof_acq_sequencer;

  localparam int NB = 9;

  logic          clk = 1'b0;
  logic          res;
  logic          start, laser_fire, tdc_valid, peak_done, alg_ready;
  logic [NB-1:0] peak_ch, peak_fh;
  logic          his_num, hist_wr_en, clr_en, acq_count_finish, busy;
  logic          result_valid, timeout_err;
  logic [NB-1:0] clr_addr, result_ch, result_fh;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct { logic [NB-1:0] ch; logic [NB-1:0] fh; } res_t;
  res_t          sb_q[$];
  logic [NB-1:0] last_ch;

  dtof_acq_sequencer #(
    .NB(NB), .CH_SHOTS(4), .FH_SHOTS(4), .TIMEOUT(20), .CW(16)
  ) dut (
    .clk(clk), .res(res), .start(start), .laser_fire(laser_fire),
    .tdc_valid(tdc_valid), .peak_done(peak_done), .alg_ready(alg_ready),
    .peak_ch(peak_ch), .peak_fh(peak_fh), .his_num(his_num),
    .hist_wr_en(hist_wr_en), .clr_en(clr_en), .clr_addr(clr_addr),
    .acq_count_finish(acq_count_finish), .busy(busy),
    .result_valid(result_valid), .result_ch(result_ch),
    .result_fh(result_fh), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every result_valid cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL result_unexpected: got result_valid=1, expected no pending result");
      end else begin
        res_t e;
        e = sb_q.pop_front();
        check("result_ch", 32'(result_ch), 32'(e.ch));
        check("result_fh", 32'(result_fh), 32'(e.fh));
      end
    end
  end

  // Hard stop in case the sequencing gets lost.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();  @(posedge clk); #1; endtask
  task automatic samp();  #3;             endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Entered at the first clear cycle; checks the whole 512-address sweep.
  task automatic do_clear(input logic exp_his);
    int bad = 0;
    for (int i = 0; i < (1 << NB); i++) begin
      samp();
      if (clr_en !== 1'b1 || clr_addr !== NB'(i) || hist_wr_en !== 1'b0 ||
          his_num !== exp_his || busy !== 1'b1 || result_valid !== 1'b0) bad++;
      tick();
    end
    check("clear_sweep_errors", 32'(bad), 32'd0);
  endtask

  // Entered at the first ACQ cycle; ends in the second PEAK cycle.
  task automatic do_shots(input int n, input int gap, input logic exp_his);
    int bad = 0;
    for (int s = 0; s < n; s++) begin
      repeat (gap) begin
        samp();
        if (hist_wr_en !== 1'b1 || acq_count_finish !== 1'b0 || clr_en !== 1'b0) bad++;
        tick();
      end
      laser_fire = 1'b1;
      samp();
      if (hist_wr_en !== 1'b1) bad++;
      if (s == n - 1) check("wr_on_final_shot", 32'(hist_wr_en), 32'd1);
      tick();
      laser_fire = 1'b0;
    end
    check("acq_gating_errors", 32'(bad), 32'd0);
    samp();
    check("peak_acq_finish", 32'(acq_count_finish), 32'd1);
    check("peak_wr_blocked", 32'(hist_wr_en), 32'd0);
    check("peak_his_num", 32'(his_num), 32'(exp_his));
    tick();
  endtask

  // Peak handshake after 'wait_cyc' extra PEAK cycles.
  task automatic do_peak(input logic is_fh, input logic [NB-1:0] bin, input int wait_cyc);
    repeat (wait_cyc) tick();
    peak_done = 1'b1;
    if (is_fh) begin
      peak_fh = bin;
      sb_q.push_back('{ch: last_ch, fh: bin});
    end else begin
      peak_ch = bin;
      last_ch = bin;
    end
    tick();
    peak_done = 1'b0;
    samp();
    if (!is_fh) begin
      check("win_his_num", 32'(his_num), 32'd1);
      check("win_wr_blocked", 32'(hist_wr_en), 32'd0);
      check("win_acq_finish", 32'(acq_count_finish), 32'd0);
    end else begin
      check("done_result_valid", 32'(result_valid), 32'd1);
    end
    tick();
  endtask

  task automatic do_alg(input int wait_cyc);
    repeat (wait_cyc) tick();
    alg_ready = 1'b1; tick(); alg_ready = 1'b0;
  endtask

  // Entered in the cycle after DONE.
  task automatic finish_frame();
`ifdef DTOF_CONT_MODE_EN
    #1;
    check("cont_clr_after_done", 32'({clr_en, busy, clr_addr}), 32'({2'b11, 9'd0}));
`else
    samp();
    check("idle_after_done", 32'({busy, clr_en, his_num, result_valid}), 32'd0);
    tick();
`endif
  endtask

  task automatic run_frame(input logic with_start, input logic [NB-1:0] ch,
                           input logic [NB-1:0] fh, input int hs_wait);
    if (with_start) do_start();
    do_clear(1'b0);
    do_shots(4, 2, 1'b0);
    do_peak(1'b0, ch, 0);
    do_alg(hs_wait);
    do_clear(1'b1);
    do_shots(4, 1, 1'b1);
    do_peak(1'b1, fh, hs_wait);
    finish_frame();
  endtask

  task automatic pulse_reset();
    #2 res = 1'b1;
    #2 res = 1'b0;
    tick();
  endtask

  initial begin
    res = 1'b1; start = 1'b0; laser_fire = 1'b0; tdc_valid = 1'b1;
    peak_done = 1'b0; alg_ready = 1'b0; peak_ch = '0; peak_fh = '0; last_ch = '0;
    #3;
    check("reset_outputs", 32'({his_num, hist_wr_en, clr_en, clr_addr, acq_count_finish,
                                busy, result_valid, result_ch, result_fh, timeout_err}), 32'd0);
    #20 res = 1'b0;
    tick();
    laser_fire = 1'b1;
    samp();
    check("idle_gated", 32'({busy, hist_wr_en, clr_en}), 32'd0);
    tick();
    laser_fire = 1'b0;

    // Nominal frame; in continuous mode a second frame follows without start.
    run_frame(1'b1, 9'd108, 9'd300, 0);
`ifdef DTOF_CONT_MODE_EN
    run_frame(1'b0, 9'd77, 9'd400, 0);
    pulse_reset();
`endif

    // Timeout: no peak_done in PEAK_CH (entry edge E0, ERR expected at E20).
    do_start();
    do_clear(1'b0);
    do_shots(4, 1, 1'b0);
    repeat (18) tick();
    samp();
    check("pre_timeout_state", 32'({busy, acq_count_finish, timeout_err}), 32'b110);
    tick();
    samp();
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    check("err_outputs", 32'({busy, acq_count_finish, his_num, clr_en}), 32'd0);
    tick();
    tick();
    samp();
    check("err_sticky", 32'({timeout_err, busy}), 32'b10);
    tick();
    do_start();
    #1;
    check("start_clears_err", 32'({timeout_err, clr_en}), 32'b01);

    // Continue to ACQ_FH, then reset asynchronously mid-pass.
    do_clear(1'b0);
    do_shots(4, 1, 1'b0);
    do_peak(1'b0, 9'd200, 0);
    do_alg(0);
    do_clear(1'b1);
    laser_fire = 1'b1; tick(); laser_fire = 1'b0; tick();
    #2 res = 1'b1;
    #1;
    check("reset_midframe_outputs",
          32'({his_num, hist_wr_en, clr_en, clr_addr, acq_count_finish,
               busy, result_valid, result_ch, result_fh, timeout_err}), 32'd0);
    #2 res = 1'b0;
    tick();
    samp();
    check("idle_after_reset", 32'({busy, his_num}), 32'd0);
    tick();

    // Clean frame after reset: extreme bins, handshakes on the last allowed cycle.
    last_ch = '0;
    run_frame(1'b1, 9'd0, 9'd511, 18);
`ifdef DTOF_CONT_MODE_EN
    pulse_reset();
`endif

    repeat (3) tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dtof_acq_sequencer.md
Name: dtof_acq_sequencer

Overview:
- Top-level controller for one dTOF pixel's two-pass histogram pipeline.
- Sequences each frame through: clear histogram RAM -> coarse-histogram (CH) acquisition -> CH peak detection -> threshold/window computation -> clear -> fine-histogram (FH) acquisition -> FH peak detection -> result.
- Drives his_num, gates TDC hits into the histogram builder, and handshakes with the peak detector and the algebraic block.
- Latches the final CH/FH peak bins for readout.

Parameters:
- NB, 9, histogram bin address width (2^NB bins per histogram)
- CH_SHOTS, 16, laser shots accumulated in the CH pass (>=1)
- FH_SHOTS, 16, laser shots accumulated in the FH pass (>=1)
- TIMEOUT, 1023, max cycles waited for peak_done or alg_ready before error
- CW, 16, width of shot and timeout counters

Ports:
- clk  input  1  system clock, rising edge
- res  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle frame start request
- laser_fire  input  1  one-cycle pulse per laser shot (shot boundary)
- tdc_valid  input  1  hit strobe from TDC/DF path
- peak_done  input  1  peak detector finished current histogram (level or pulse)
- alg_ready  input  1  algebraic block window thresholds valid
- peak_ch  input  NB  coarse peak bin from peak detector
- peak_fh  input  NB  fine peak bin from peak detector
- his_num  output  1  0 = CH pass, 1 = FH pass
- hist_wr_en  output  1  gated write enable to histogram builder
- clr_en  output  1  histogram RAM clear-write strobe
- clr_addr  output  NB  address being cleared
- acq_count_finish  output  1  acquisition of current pass complete, peak search enable
- busy  output  1  high in every state except IDLE and ERR
- result_valid  output  1  one-cycle pulse, results latched
- result_ch  output  NB  latched coarse peak bin
- result_fh  output  NB  latched fine peak bin
- timeout_err  output  1  sticky handshake-timeout flag

Behaviour:
- Reset (res=1, async): state IDLE, all outputs 0, all counters 0.
- States: IDLE, CLR_CH, ACQ_CH, PEAK_CH, WIN, CLR_FH, ACQ_FH, PEAK_FH, DONE, ERR. Registered Moore FSM; outputs decode from state except hist_wr_en.
- IDLE: start=1 -> CLR_CH; clears timeout_err. start in any other state except ERR is ignored.
- CLR_CH / CLR_FH:
  - clr_en=1; clr_addr counts 0..2^NB-1, one per cycle (2^NB cycles total).
  - At the cycle with clr_addr = 2^NB-1, go to ACQ_CH / ACQ_FH. clr_addr returns to 0.
- ACQ_CH / ACQ_FH:
  - hist_wr_en = tdc_valid AND (state is ACQ_CH or ACQ_FH), combinational, zero latency; hits outside ACQ states are dropped.
  - Shot counter increments on laser_fire.
  - The laser_fire that makes count = CH_SHOTS (or FH_SHOTS) moves to PEAK_* next cycle and resets the counter.
  - A tdc_valid coincident with that final laser_fire is still written.
- PEAK_CH / PEAK_FH:
  - acq_count_finish=1.
  - On peak_done=1: PEAK_CH -> WIN, capturing peak_ch into result_ch; PEAK_FH -> DONE, capturing peak_fh into result_fh.
- WIN: his_num=1 (pre-set for FH). alg_ready=1 -> CLR_FH.
- Timeout:
  - Counter runs in PEAK_CH, WIN and PEAK_FH; it is cleared on every state entry.
  - Reaching TIMEOUT cycles without the awaited handshake -> ERR with timeout_err=1.
  - If the handshake and the TIMEOUT-th cycle coincide, the handshake wins.
- his_num: 0 in CLR_CH..PEAK_CH; 1 in WIN..DONE; 0 in IDLE/ERR.
- DONE: result_valid=1 for exactly one cycle, then IDLE. result_ch/result_fh hold until the next capture or reset.
- ERR: busy=0; timeout_err stays 1; start -> CLR_CH (clears flag).
- laser_fire/tdc_valid outside ACQ states: no effect.
- res asserted mid-frame: immediate IDLE; partial results are discarded (result_* return to 0).

Optional Feature:
- Macro: DTOF_CONT_MODE_EN.
- Defined: DONE transitions directly to CLR_CH (free-running frames, no start needed after the first); result_valid still pulses each frame; ERR still halts until start.
- Undefined: DONE -> IDLE as above.

Test Plan:
- Nominal frame (NB=9, CH_SHOTS=4, FH_SHOTS=4):
  - Stimulus: start; 4 laser_fire in ACQ_CH; peak_done with peak_ch=108; alg_ready; 4 laser_fire; peak_done with peak_fh=300.
  - Required: result_valid single pulse, result_ch=108, result_fh=300, his_num 0->1 at WIN entry.
- Clear sweep:
  - Stimulus: start.
  - Required: clr_en high exactly 512 cycles, clr_addr 0..511 sequential, no hist_wr_en during clear even with tdc_valid=1.
- Gating:
  - Stimulus: tdc_valid every cycle across the whole frame.
  - Required: hist_wr_en only in ACQ states, including the cycle of the final laser_fire; 0 in PEAK/WIN.
- Timeout:
  - Stimulus: TIMEOUT=20, no peak_done.
  - Required: ERR 20 cycles after PEAK_CH entry, timeout_err=1, busy=0; a new start clears the flag and enters CLR_CH.
- Reset mid-operation:
  - Stimulus: res pulse (non-clock-aligned) during ACQ_FH.
  - Required: all outputs 0 asynchronously, FSM in IDLE, subsequent start runs a clean frame.
- DTOF_CONT_MODE_EN defined:
  - Stimulus: one start, then complete stimulus for two frames.
  - Required: two result_valid pulses; CLR_CH follows DONE with no IDLE cycle.
